// File: rtl/clk_step_ctrl.sv
// Run/step clock-enable controller: divides clk_in into ce pulses, free-running or single-step.
// Define CLK_STEP_CTRL_CYCLE_COUNT_EN to implement the ce pulse counter on cycle_count.
module clk_step_ctrl #(
  parameter int unsigned DIV_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             ce,
  output logic             clk_out,
  output logic             step_done,
  output logic [1:0]       state_out,
  output logic [31:0]      cycle_count
);

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] One = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             clk_out_q;
  logic             div_ack_q;
  logic             step_prev_q;

  logic [DIV_W-1:0] div_eff;
  logic             step_edge;
  logic             load_accept;

  // A zero divisor behaves as divide-by-one.
  assign div_eff   = (div_q == '0) ? One : div_q;
  assign ce        = (state_q != StHalt) && (cnt_q == div_eff - One);
  assign step_edge = step_req & ~step_prev_q;

  // The ack cycle is blocked so a request still held high is not taken twice.
  assign load_accept = div_load & ~div_ack_q & ((state_q == StHalt) | ce);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      StHalt: begin
        cnt_d = '0;
        if (run_req) begin
          state_d = StRun;
        end else if (step_edge) begin
          state_d = StStep;
        end
      end
      StRun: begin
        if (!run_req) begin
          state_d = StHalt;
          cnt_d   = '0;
        end else begin
          cnt_d = ce ? '0 : cnt_q + One;
        end
      end
      StStep: begin
        if (ce) begin
          state_d = StHalt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      default: begin
        state_d = StHalt;
        cnt_d   = '0;
      end
    endcase
    if (load_accept) begin
      div_d = div_in;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= StHalt;
      cnt_q       <= '0;
      div_q       <= DIV_W'(DEFAULT_DIV);
      clk_out_q   <= 1'b0;
      div_ack_q   <= 1'b0;
      step_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      clk_out_q   <= clk_out_q ^ ce;
      div_ack_q   <= load_accept;
      step_prev_q <= step_req;
    end
  end

  assign div_ack   = div_ack_q;
  assign clk_out   = clk_out_q;
  assign step_done = ce && (state_q == StStep);
  assign state_out = state_q;

`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cycle_count_q <= 32'd0;
    end else if (ce) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed bench for clk_step_ctrl with DEFAULT_DIV=4; cycle_count expectations follow the macro.
module tb_clk_step_ctrl;

`ifdef CLK_STEP_CTRL_CYCLE_COUNT_EN
  localparam bit CcEn = 1'b1;
`else
  localparam bit CcEn = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        run_req = 1'b0;
  logic        step_req = 1'b0;
  logic [31:0] div_in = 32'd0;
  logic        div_load = 1'b0;
  logic        div_ack;
  logic        ce;
  logic        clk_out;
  logic        step_done;
  logic [1:0]  state_out;
  logic [31:0] cycle_count;

  int total = 0;
  int bad = 0;

  clk_step_ctrl #(
    .DIV_W      (32),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .run_req    (run_req),
    .step_req   (step_req),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_ack    (div_ack),
    .ce         (ce),
    .clk_out    (clk_out),
    .step_done  (step_done),
    .state_out  (state_out),
    .cycle_count(cycle_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({state_out, ce, clk_out, div_ack, step_done} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {state_out, ce, clk_out, div_ack, step_done});
    end
    total++;
    if (cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_count: got %0d want 0", cycle_count);
    end
  endtask

  task automatic test_run();
    logic exp_clk;
    logic [3:0] exp;
    exp_clk = 1'b0;
    run_req = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      exp = {(k % 4 == 0), exp_clk, 2'd1};
      total++;
      if ({ce, clk_out, state_out} !== exp) begin
        bad++;
        $display("FAIL run_cycle%0d {ce,clk_out,state}: got %b want %b", k,
                 {ce, clk_out, state_out}, exp);
      end
      if (k % 4 == 0) exp_clk = ~exp_clk;
      if (k == 20) run_req = 1'b0;
      tick();
    end
    total++;
    if ({state_out, ce, clk_out} !== {2'd0, 1'b0, exp_clk}) begin
      bad++;
      $display("FAIL run_halt {state,ce,clk_out}: got %b want %b",
               {state_out, ce, clk_out}, {2'd0, 1'b0, exp_clk});
    end
    total++;
    if (cycle_count !== (CcEn ? 32'd5 : 32'd0)) begin
      bad++;
      $display("FAIL run_count: got %0d want %0d", cycle_count, CcEn ? 5 : 0);
    end
  endtask

  task automatic test_step();
    logic [3:0] exp;
    step_req = 1'b1;
    tick();
    total++;
    if (state_out !== 2'd2) begin
      bad++;
      $display("FAIL step_enter: got %0d want 2", state_out);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) step_req = 1'b0;
      if (k == 2) begin
        step_req = 1'b1;
        run_req  = 1'b1;
      end
      if (k == 3) run_req = 1'b0;
      exp = {(k == 4), (k == 4), 2'd2};
      total++;
      if ({ce, step_done, state_out} !== exp) begin
        bad++;
        $display("FAIL step_cycle%0d {ce,done,state}: got %b want %b", k,
                 {ce, step_done, state_out}, exp);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      total++;
      if ({ce, step_done, state_out} !== 4'b0) begin
        bad++;
        $display("FAIL step_exit%0d {ce,done,state}: got %b want 0000", k,
                 {ce, step_done, state_out});
      end
      tick();
    end
    step_req = 1'b0;
    total++;
    if (cycle_count !== (CcEn ? 32'd6 : 32'd0)) begin
      bad++;
      $display("FAIL step_count: got %0d want %0d", cycle_count, CcEn ? 6 : 0);
    end
  endtask

  task automatic test_load_run();
    logic [1:0] exp;
    run_req = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        div_in   = 32'd2;
        div_load = 1'b1;
      end
      exp = {(k == 4 || k == 6 || k == 8), (k == 5)};
      total++;
      if ({ce, div_ack} !== exp) begin
        bad++;
        $display("FAIL load_cycle%0d {ce,ack}: got %b want %b", k, {ce, div_ack}, exp);
      end
      if (k == 5) div_load = 1'b0;
      if (k == 8) run_req = 1'b0;
      tick();
    end
    total++;
    if (cycle_count !== (CcEn ? 32'd9 : 32'd0)) begin
      bad++;
      $display("FAIL load_count: got %0d want %0d", cycle_count, CcEn ? 9 : 0);
    end
  endtask

  task automatic test_zero_div();
    div_in   = 32'd0;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    total++;
    if (div_ack !== 1'b1) begin
      bad++;
      $display("FAIL zero_ack: got %b want 1", div_ack);
    end
    tick();
    total++;
    if (div_ack !== 1'b0) begin
      bad++;
      $display("FAIL zero_ack_pulse: got %b want 0", div_ack);
    end
    run_req = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      total++;
      if ({ce, state_out} !== 3'b101) begin
        bad++;
        $display("FAIL zero_cycle%0d {ce,state}: got %b want 101", k, {ce, state_out});
      end
      if (k == 3) run_req = 1'b0;
      tick();
    end
    total++;
    if (cycle_count !== (CcEn ? 32'd12 : 32'd0)) begin
      bad++;
      $display("FAIL zero_count: got %0d want %0d", cycle_count, CcEn ? 12 : 0);
    end
  endtask

  task automatic test_race_reset();
    logic [3:0] exp;
    div_in   = 32'd5;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    run_req  = 1'b1;
    step_req = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      exp = {2'd1, 1'b0, (k == 5)};
      total++;
      if ({state_out, step_done, ce} !== exp) begin
        bad++;
        $display("FAIL race_cycle%0d {state,done,ce}: got %b want %b", k,
                 {state_out, step_done, ce}, exp);
      end
      if (k < 8) tick();
    end
    // Cycle 8 has cnt=2 with a load pending; reset must abort both.
    div_in   = 32'd9;
    div_load = 1'b1;
    rst      = 1'b1;
    run_req  = 1'b0;
    tick();
    rst      = 1'b0;
    div_load = 1'b0;
    total++;
    if ({state_out, ce, clk_out, div_ack, step_done} !== 6'b0) begin
      bad++;
      $display("FAIL midrun_reset: got %b want 000000",
               {state_out, ce, clk_out, div_ack, step_done});
    end
    total++;
    if (cycle_count !== 32'd0) begin
      bad++;
      $display("FAIL midrun_reset_count: got %0d want 0", cycle_count);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if ({state_out, ce, div_ack, step_done} !== 5'b0) begin
        bad++;
        $display("FAIL post_reset%0d: got %b want 00000", k,
                 {state_out, ce, div_ack, step_done});
      end
    end
    // Reset must restore the default divisor of 4.
    step_req = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      total++;
      if ({ce, step_done} !== {(k == 4), (k == 4)}) begin
        bad++;
        $display("FAIL default_div_step%0d {ce,done}: got %b want %b", k,
                 {ce, step_done}, {(k == 4), (k == 4)});
      end
      tick();
    end
    step_req = 1'b0;
    total++;
    if (cycle_count !== (CcEn ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL default_div_count: got %0d want %0d", cycle_count, CcEn ? 1 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_load_run();
    test_zero_div();
    test_race_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 32, width of the divisor and internal period counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 100, divisor loaded at reset; legal range 1..2^DIV_W-1.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port run_req  input  1  level; high requests free-running enables.
REQ-006 SHALL have port step_req  input  1  rising edge requests exactly one enable pulse.
REQ-007 SHALL have port div_in  input  DIV_W  new divisor value.
REQ-008 SHALL have port div_load  input  1  divisor load request; held high until div_ack.
REQ-009 SHALL have port div_ack  output  1  one-cycle pulse: div_in captured.
REQ-010 SHALL have port ce  output  1  one-cycle clock-enable pulse to the CPU datapath.
REQ-011 SHALL have port clk_out  output  1  square wave toggling on every ce.
REQ-012 SHALL have port step_done  output  1  one-cycle pulse: single step finished.
REQ-013 SHALL have port state_out  output  2  current state: 0 HALT, 1 RUN, 2 STEP.
REQ-014 SHALL have port cycle_count  output  32  count of ce pulses issued.

Function
REQ-015 SHALL hold an active divisor div_r and a period counter cnt; an effective divisor of 0 SHALL be treated as 1.
REQ-016 In RUN or STEP, cnt SHALL increment each cycle; when cnt == div_r-1, ce SHALL be high for that cycle and cnt SHALL return to 0.
REQ-017 In HALT, cnt SHALL be held at 0 and ce SHALL be 0.
REQ-018 ce period in RUN SHALL be exactly div_r cycles; the first ce after entering RUN/STEP SHALL occur div_r cycles after the transition edge.
REQ-019 clk_out SHALL toggle on the cycle after each ce and otherwise hold its value, including in HALT.
REQ-020 step_req SHALL be edge-detected with a register reset to 1, so a step_req held high through reset produces no step.
REQ-021 HALT->RUN when run_req=1; HALT->STEP on step_req rising edge with run_req=0; run_req plus step edge in the same cycle: RUN wins, the step is discarded.
REQ-022 RUN->HALT on the cycle after run_req is sampled 0, cnt cleared, no partial ce.
REQ-023 STEP SHALL ignore run_req and step edges, issue exactly one ce, then return to HALT on the next cycle; step_done SHALL be high in the same cycle as that ce.
REQ-024 Step edges in RUN SHALL be ignored.
REQ-025 div_load SHALL be accepted in HALT or in a cycle where ce=1; on accept, div_r<=div_in, cnt<=0, and div_ack pulses the following cycle; a request in any other cycle waits.
REQ-026 After div_ack, the loaded divisor SHALL govern the next full period; no truncated period SHALL occur.
REQ-027 cycle_count SHALL increment by 1 on each ce and wrap from 2^32-1 to 0.

Reset
REQ-028 On rst=1 at a clock edge: state HALT, cnt 0, div_r DEFAULT_DIV, ce 0, clk_out 0, div_ack 0, step_done 0, cycle_count 0, step edge register 1.
REQ-029 Reset mid-RUN/STEP or with a pending load SHALL abort the operation; no ce or div_ack SHALL follow the reset.

Configuration
REQ-030 Macro CLK_STEP_CTRL_CYCLE_COUNT_EN defined: cycle_count SHALL be implemented per REQ-027.
REQ-031 Macro undefined: cycle_count SHALL be constant 0 and no counter register SHALL be synthesised; all other behaviour is unchanged.

Verification (DEFAULT_DIV=4, macro defined unless stated)
REQ-032 Reset, run_req=1 for 20 cycles -> ce at cycles 4,8,12,16,20 after the edge; clk_out toggles after each; cycle_count=5.
REQ-033 HALT, step_req pulse 0->1 -> state STEP, one ce plus step_done 4 cycles later, state HALT next cycle; further steps while in STEP are ignored.
REQ-034 RUN, div_load with div_in=2 asserted mid-period -> accepted at next ce, div_ack the next cycle, then ce every 2 cycles.
REQ-035 HALT, div_in=0 load -> div_ack; run -> ce every cycle.
REQ-036 run_req and step edge in the same HALT cycle -> RUN, no step_done; rst mid-RUN with cnt=2 -> no ce, all outputs at reset values.
REQ-037 Macro undefined, 10 ce pulses -> cycle_count stays 0.
